// File: rtl/mul_acc_pkg.sv
// Shared types and default sizing for the multiplier-result accumulator.
package mul_acc_pkg;

    // Frame tracking state: waiting for a first beat, or inside a frame.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } frame_state_e;

    localparam int DEF_LATENCY = 2;
    localparam int DEF_ACC_W   = 72;
    localparam int DEF_CNT_W   = 16;
    localparam int PRODUCT_W   = 64;

endpackage

// File: rtl/valid_delay_line.sv
// LATENCY-deep shift register carrying {last, valid} alongside the
// multiplier pipeline so that the beat flags line up with its product.
module valid_delay_line #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] vl_i,
    output logic [1:0] vl_o
);

    logic [LATENCY-1:0][1:0] stage_q;

    // Shift the beat flags one stage per cycle; reset empties the pipe so
    // products in flight at reset release are never treated as beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= vl_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign vl_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mul_accumulator.sv
// Frame accumulator behind the pipelined 32x32 multiplier.
// Sums the 64-bit products of each framed beat sequence and presents the
// frame sum and beat count on a valid/ready output register. Never stalls
// the multiplier; frames that cannot be stored are dropped and flagged.
// Build option: define MUL_ACC_SATURATE_EN to clamp the sum on overflow
// and report it on out_sat; otherwise the sum wraps and out_sat is 0.
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [PRODUCT_W-1:0] r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_sat,
    output logic                 overrun
);

`ifdef MUL_ACC_SATURATE_EN
    localparam int SUM_W = ACC_W + 1;   // keep the carry to detect overflow
`else
    localparam int SUM_W = ACC_W;       // plain modulo-2^ACC_W addition
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Beat flags realigned with r.
    logic [1:0]           dl_out_s;
    logic                 p_valid_s;
    logic                 p_last_s;

    // Registered copy of the aligned beat, decoupling r from the adder.
    logic                 cap_valid_q;
    logic                 cap_last_q;
    logic [PRODUCT_W-1:0] cap_r_q;

    // Frame state.
    frame_state_e         state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic [SUM_W-1:0]     sum_s;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic                 done_s;

    // Output register.
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     out_sum_q, out_sum_d;
    logic [CNT_W-1:0]     out_count_q, out_count_d;
    logic                 out_sat_q, out_sat_d;
    logic                 overrun_q, overrun_d;

    valid_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .vl_i  ({in_valid & in_last, in_valid}),
        .vl_o  (dl_out_s)
    );

    assign p_valid_s = dl_out_s[0];
    assign p_last_s  = dl_out_s[1];

    // Capture the aligned product and its flags; r is only sampled on beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_last_q  <= 1'b0;
            cap_r_q     <= '0;
        end else begin
            cap_valid_q <= p_valid_s;
            cap_last_q  <= p_valid_s & p_last_s;
            if (p_valid_s) begin
                cap_r_q <= r;
            end
        end
    end

    assign sum_s     = SUM_W'(acc_q) + SUM_W'(cap_r_q);
    assign cnt_inc_s = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

    // Frame FSM: start, extend and close frames; completion exposes the
    // updated sum/count through acc_d/cnt_d/sat_d.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_valid_q) begin
                    acc_d = ACC_W'(cap_r_q);
                    cnt_d = CNT_ONE;
                    sat_d = 1'b0;
                    if (cap_last_q) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (cap_valid_q) begin
                    cnt_d = cnt_inc_s;
`ifdef MUL_ACC_SATURATE_EN
                    if (sat_q || sum_s[ACC_W]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_s[ACC_W-1:0];
                        sat_d = 1'b0;
                    end
`else
                    acc_d = sum_s;
`endif
                    if (cap_last_q) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame state registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Output slot: load on completion when empty or draining this edge,
    // otherwise drop the new frame and raise the sticky overrun flag.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        overrun_d   = overrun_q;
        if (done_s) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_sum_d   = acc_d;
                out_count_d = cnt_d;
                out_sat_d   = sat_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed scoreboard bench for mul_accumulator, with a 2-stage multiplier
// model in front and a second ACC_W=64 instance for the overflow case.
module tb_mul_accumulator;

    typedef struct packed {
        logic [71:0] sum;
        logic [15:0] cnt;
        logic        sat;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        rdy = 1'b1;
    logic        rdy64 = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [63:0] m0 = 64'd0;
    logic [63:0] m1 = 64'd0;
    logic [63:0] r;

    logic        out_valid, out_sat, overrun;
    logic [71:0] out_sum;
    logic [15:0] out_count;
    logic        o64_valid, o64_sat, o64_overrun;
    logic [63:0] o64_sum;
    logic [15:0] o64_count;

    frame_t      sb_q[$];
    frame_t      e;
    int          checks = 0;
    int          errors = 0;
    logic [71:0] exp_sum = 72'd0;
    logic [15:0] exp_cnt = 16'd0;
    logic [4:0]  ov;

    mul_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (rdy),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat),
        .overrun   (overrun)
    );

    mul_accumulator #(.ACC_W(64)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .r         (r),
        .out_valid (o64_valid),
        .out_ready (rdy64),
        .out_sum   (o64_sum),
        .out_count (o64_count),
        .out_sat   (o64_sat),
        .overrun   (o64_overrun)
    );

    always #5 clk = ~clk;

    // Multiplier model: operands sampled at edge t, product on r after t+1.
    always @(posedge clk) begin
        m0 <= 64'(a) * 64'(b);
        m1 <= m0;
    end
    assign r = m1;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of operands; the model tracks the running frame.
    task automatic beat(input logic [31:0] av, input logic [31:0] bv,
                        input logic v, input logic last, input logic push);
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        in_valid = v;
        in_last  = last;
        if (v) begin
            exp_sum = exp_sum + 72'(64'(av) * 64'(bv));
            exp_cnt = exp_cnt + 16'd1;
            if (last) begin
                if (push) sb_q.push_back('{exp_sum, exp_cnt, 1'b0});
                exp_sum = 72'd0;
                exp_cnt = 16'd0;
            end
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) beat(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every accepted frame must match the oldest expected.
    always @(negedge clk) begin
        if (rst_n && out_valid && rdy) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed sum=%0h expected no frame", out_sum);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_sum", 80'(out_sum), 80'(e.sum));
                check("sb_count", 80'(out_count), 80'(e.cnt));
                check("sb_sat", 80'(out_sat), 80'(e.sat));
            end
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", 80'(out_valid), 80'd0);
        check("rst_sum", 80'(out_sum), 80'd0);
        check("rst_count", 80'(out_count), 80'd0);
        check("rst_overrun", 80'(overrun), 80'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Three-beat frame, valid window exactly at last-sample edge + 3.
        beat(32'd2, 32'd3, 1'b1, 1'b0, 1'b1);
        beat(32'd4, 32'd5, 1'b1, 1'b0, 1'b1);
        beat(32'd6, 32'd7, 1'b1, 1'b1, 1'b1);
        beat(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ov[k] = out_valid;
        end
        check("t1_valid_window", 80'(ov), 80'(5'b01000));
        idle_n(3);

        // Single full-scale beat.
        beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        idle_n(6);

        // Bubbles inside a frame.
        beat(32'd1, 32'd1, 1'b1, 1'b0, 1'b1);
        idle_n(2);
        beat(32'd2, 32'd2, 1'b1, 1'b1, 1'b1);
        idle_n(6);

        // Output blocked: second frame dropped, first held.
        @(posedge clk);
        #1 rdy = 1'b0;
        beat(32'd3, 32'd3, 1'b1, 1'b1, 1'b1);
        beat(32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
        idle_n(6);
        @(negedge clk);
        check("ovr_valid", 80'(out_valid), 80'd1);
        check("ovr_sum", 80'(out_sum), 80'd9);
        check("ovr_count", 80'(out_count), 80'd1);
        check("ovr_flag", 80'(overrun), 80'd1);
        @(posedge clk);
        #1 rdy = 1'b1;
        idle_n(3);
        @(negedge clk);
        check("ovr_drained", 80'(out_valid), 80'd0);
        check("ovr_sticky", 80'(overrun), 80'd1);

        // Overflow of a 64-bit accumulator.
        beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        beat(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !o64_valid; i++) @(negedge clk);
        check("w64_seen", 80'(o64_valid), 80'd1);
`ifdef MUL_ACC_SATURATE_EN
        check("w64_sum", 80'(o64_sum), 80'hFFFFFFFFFFFFFFFF);
        check("w64_sat", 80'(o64_sat), 80'd1);
`else
        check("w64_sum", 80'(o64_sum), 80'hFFFFFFFC00000002);
        check("w64_sat", 80'(o64_sat), 80'd0);
`endif
        check("w64_count", 80'(o64_count), 80'd2);
        idle_n(6);

        // Reset mid-frame discards the partial frame.
        beat(32'd9, 32'd9, 1'b1, 1'b0, 1'b1);
        beat(32'd9, 32'd9, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp_sum  = 72'd0;
        exp_cnt  = 16'd0;
        @(negedge clk);
        check("mrst_valid", 80'(out_valid), 80'd0);
        check("mrst_sum", 80'(out_sum), 80'd0);
        check("mrst_count", 80'(out_count), 80'd0);
        check("mrst_sat", 80'(out_sat), 80'd0);
        check("mrst_overrun", 80'(overrun), 80'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(32'd7, 32'd8, 1'b1, 1'b1, 1'b1);
        idle_n(8);

        check("sb_empty", 80'(sb_q.size()), 80'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
